// File: rtl/vending_pkg.sv
// Shared coin codes, coin values, FSM states and fault codes for the vending
// change path.
package vending_pkg;

   typedef logic [1:0] coin_code_t;

   localparam coin_code_t COIN_500  = 2'b00;
   localparam coin_code_t COIN_1000 = 2'b01;
   localparam coin_code_t COIN_2000 = 2'b10;
   localparam coin_code_t COIN_5000 = 2'b11;

   typedef enum logic [2:0] {IDLE, CALC, DISPENSE, DONE, FAULT} state_t;

   localparam logic [1:0] FC_NONE      = 2'b00;
   localparam logic [1:0] FC_UNDERPAID = 2'b01;
   localparam logic [1:0] FC_NO_CHANGE = 2'b10;

   // Coin face value expressed in 500-units.
   function automatic logic [3:0] coin_value(input coin_code_t code);
      logic [3:0] v;
      case (code)
         COIN_500:  v = 4'd1;
         COIN_1000: v = 4'd2;
         COIN_2000: v = 4'd4;
         default:   v = 4'd10;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// Four saturating coin counters (one per denomination) with low-stock flags.
module coin_inventory
   import vending_pkg::*;
#(
   parameter int INV_W    = 4,
   parameter int INV_INIT = 10,
   parameter int LOW_MARK = 2
)
(
   input  logic             clock,
   input  logic             clr_n,
   input  logic             dec_en,
   input  coin_code_t       dec_code,
   input  logic             inc_en,
   input  coin_code_t       inc_code,
   output logic [INV_W-1:0] count [4],
   output logic [3:0]       low_warn
);

   logic [INV_W-1:0] r_count [4];

   always_ff @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (!clr_n) begin
            r_count[i] <= INV_W'(INV_INIT);
         end else if (dec_en && (dec_code == coin_code_t'(i)) && (r_count[i] != '0)) begin
            r_count[i] <= r_count[i] - 1'b1;
         end else if (inc_en && (inc_code == coin_code_t'(i)) && (r_count[i] != '1)) begin
            r_count[i] <= r_count[i] + 1'b1;
         end
      end
   end

   always_comb begin
      low_warn = '0;
      for (int i = 0; i < 4; i++) begin
         low_warn[i] = (r_count[i] < INV_W'(LOW_MARK));
      end
   end

   assign count = r_count;

endmodule

// File: rtl/change_dispenser.sv
// Pays out (paid - price) one coin at a time, greedy over the stocked coins.
// Optional COIN_GAP_EN inserts one idle cycle after every accepted coin.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int MONEY_W  = 8,
   parameter int INV_W    = 4,
   parameter int INV_INIT = 10,
   parameter int LOW_MARK = 2
)
(
   input  logic               clock,
   input  logic               clr_n,
   input  logic               start,
   input  logic [MONEY_W-1:0] paid_units,
   input  logic [MONEY_W-1:0] price_units,
   output logic               coin_valid,
   output logic [1:0]         coin_code,
   input  logic               coin_ready,
   output logic               busy,
   output logic               done,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [MONEY_W-1:0] remaining_units,
   input  logic               fault_clr,
   input  logic               refill,
   input  logic [1:0]         refill_code,
   output logic [3:0]         low_warn
);

   state_t             r_state;
   logic [MONEY_W-1:0] r_paid;
   logic [MONEY_W-1:0] r_price;
   logic [MONEY_W-1:0] r_rem;
   logic               r_busy;
   logic               r_done;
   logic               r_fault;
   logic [1:0]         r_fc;

   logic [INV_W-1:0]   w_count [4];
   logic [MONEY_W-1:0] w_val [4];
   logic [MONEY_W-1:0] w_rem_next;
   coin_code_t         w_sel;
   logic               w_found;
   logic               w_gap;
   logic               w_offer;
   logic               w_accept;
   logic               w_inc_en;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_val[i] = MONEY_W'(coin_value(coin_code_t'(i)));
      end
   end

   // Ascending scan so the highest stocked coin that still fits wins.
   always_comb begin
      w_found = 1'b0;
      w_sel   = COIN_500;
      for (int i = 0; i < 4; i++) begin
         if ((w_val[i] <= r_rem) && (w_count[i] != '0)) begin
            w_found = 1'b1;
            w_sel   = coin_code_t'(i);
         end
      end
   end

`ifdef COIN_GAP_EN
   logic r_gap;

   always_ff @(posedge clock) begin
      if (!clr_n) begin
         r_gap <= 1'b0;
      end else begin
         r_gap <= w_accept;
      end
   end

   assign w_gap = r_gap;
`else
   assign w_gap = 1'b0;
`endif

   assign w_offer    = (r_state == DISPENSE) && w_found && !w_gap;
   assign w_accept   = w_offer && coin_ready;
   assign w_rem_next = r_rem - w_val[w_sel];
   assign w_inc_en   = (r_state == IDLE) && refill;

   always_ff @(posedge clock) begin
      if ((r_state == IDLE) && start) begin
         r_paid  <= paid_units;
         r_price <= price_units;
      end
   end

   always_ff @(posedge clock) begin
      if (!clr_n) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_fc    <= FC_NONE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= CALC;
                  r_busy  <= 1'b1;
               end
            end
            CALC: begin
               if (r_paid < r_price) begin
                  r_fc    <= FC_UNDERPAID;
                  r_rem   <= '0;
                  r_state <= FAULT;
                  r_busy  <= 1'b0;
                  r_fault <= 1'b1;
               end else if (r_paid == r_price) begin
                  r_rem   <= '0;
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_rem   <= r_paid - r_price;
                  r_state <= DISPENSE;
               end
            end
            DISPENSE: begin
               if (w_accept) begin
                  r_rem <= w_rem_next;
                  if (w_rem_next == '0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else if (!w_found) begin
                  r_fc    <= FC_NO_CHANGE;
                  r_state <= FAULT;
                  r_busy  <= 1'b0;
                  r_fault <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            FAULT: begin
               if (fault_clr) begin
                  r_state <= IDLE;
                  r_fault <= 1'b0;
                  r_fc    <= FC_NONE;
                  r_rem   <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   coin_inventory #(
      .INV_W    (INV_W),
      .INV_INIT (INV_INIT),
      .LOW_MARK (LOW_MARK)
   ) u_inv (
      .clock    (clock),
      .clr_n    (clr_n),
      .dec_en   (w_accept),
      .dec_code (w_sel),
      .inc_en   (w_inc_en),
      .inc_code (refill_code),
      .count    (w_count),
      .low_warn (low_warn)
   );

   assign coin_valid      = w_offer;
   assign coin_code       = w_offer ? w_sel : COIN_500;
   assign busy            = r_busy;
   assign done            = r_done;
   assign fault           = r_fault;
   assign fault_code      = r_fc;
   assign remaining_units = r_rem;

endmodule
